// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back select, architectural register file and commit counter
// Register 0 reads as zero and is never written; read ports bypass the pending write.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [ADDR_W-1:0] dest_reg,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_valid,
  output logic [31:0]       commit_count
);

  localparam int NREG = 1 << ADDR_W;

  // Entry 0 exists only to keep indexing in range; it stays at its reset value of zero.
  logic [DATA_W-1:0] regs [NREG];
  logic [31:0]       count_q;

  assign wb_data  = mem_to_reg ? read_data : alu_result;
  assign wb_valid = reg_write && (dest_reg != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      count_q <= '0;
    end else if (wb_valid) begin
      regs[dest_reg] <= wb_data;
      count_q        <= count_q + 32'd1;
    end
  end

  assign rs_data = (rs_addr == '0)                     ? '0 :
                   (wb_valid && (dest_reg == rs_addr)) ? wb_data :
                                                         regs[rs_addr];
  assign rt_data = (rt_addr == '0)                     ? '0 :
                   (wb_valid && (dest_reg == rt_addr)) ? wb_data :
                                                         regs[rt_addr];

  assign commit_count = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile
// Directed table, hand-written reset/wrap sequences, then random traffic against an array model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_to_reg;
  logic        reg_write;
  logic [31:0] read_data;
  logic [31:0] alu_result;
  logic [4:0]  dest_reg;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic        wb_valid;
  logic [31:0] commit_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .read_data(read_data), .alu_result(alu_result), .dest_reg(dest_reg),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .wb_data(wb_data), .wb_valid(wb_valid), .commit_count(commit_count)
  );

  typedef struct {
    logic        mtr;
    logic        rw;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] e_wb;
    logic        e_valid;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl [7];

  logic [31:0] mdl [32];
  logic [31:0] mdl_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic mtr, input logic rw, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [4:0] dest,
                       input logic [4:0] rs, input logic [4:0] rt);
    mem_to_reg = mtr; reg_write = rw; read_data = rd; alu_result = alu;
    dest_reg = dest; rs_addr = rs; rt_addr = rt;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic valid,
                                             input logic [4:0] dest, input logic [31:0] wbv);
    if (a == 5'd0) return 32'h0;
    if (valid && dest == a) return wbv;
    return mdl[a];
  endfunction

  initial begin
    logic [31:0] e_wb;
    logic        e_valid;

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd31);
    #12;
    chk("reset_rs", rs_data, 32'h0);
    chk("reset_rt", rt_data, 32'h0);
    chk("reset_count", commit_count, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Rows chain: each row's reads depend on the commits of the rows above.
    tbl[0] = '{1'b0, 1'b1, 32'h0,        32'hDEADBEEF, 5'd8,  5'd8,  5'd0,  32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 32'h0,        32'd0};
    tbl[1] = '{1'b1, 1'b1, 32'h000000FF, 32'h11111111, 5'd9,  5'd8,  5'd9,  32'h000000FF, 1'b1, 32'hDEADBEEF, 32'h000000FF, 32'd1};
    tbl[2] = '{1'b0, 1'b1, 32'h0,        32'h00000001, 5'd10, 5'd9,  5'd8,  32'h00000001, 1'b1, 32'h000000FF, 32'hDEADBEEF, 32'd2};
    tbl[3] = '{1'b0, 1'b1, 32'h0,        32'h0000ABCD, 5'd10, 5'd10, 5'd10, 32'h0000ABCD, 1'b1, 32'h0000ABCD, 32'h0000ABCD, 32'd3};
    tbl[4] = '{1'b0, 1'b1, 32'h0,        32'hFFFFFFFF, 5'd0,  5'd0,  5'd10, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h0000ABCD, 32'd4};
    tbl[5] = '{1'b0, 1'b0, 32'h0,        32'h00005555, 5'd3,  5'd0,  5'd3,  32'h00005555, 1'b0, 32'h0,        32'h0,        32'd4};
    tbl[6] = '{1'b1, 1'b0, 32'h00000077, 32'h0,        5'd0,  5'd3,  5'd10, 32'h00000077, 1'b0, 32'h0,        32'h0000ABCD, 32'd4};

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].mtr, tbl[i].rw, tbl[i].rd, tbl[i].alu, tbl[i].dest, tbl[i].rs, tbl[i].rt);
      @(negedge clk);
      chk($sformatf("tbl%0d_wb_data", i), wb_data, tbl[i].e_wb);
      chk($sformatf("tbl%0d_wb_valid", i), {31'h0, wb_valid}, {31'h0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_rs", i), rs_data, tbl[i].e_rs);
      chk($sformatf("tbl%0d_rt", i), rt_data, tbl[i].e_rt);
      chk($sformatf("tbl%0d_count", i), commit_count, tbl[i].e_cnt);
      @(posedge clk); #1;
    end

    // Undriven load data must not matter while reg_write is low.
    drive(1'b1, 1'b0, 32'hx, 32'hx, 5'd9, 5'd9, 5'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);
    #1;
    chk("x_gated_reg9", rs_data, 32'h000000FF);
    chk("x_gated_count", commit_count, 32'd4);

    // Mid-run asynchronous reset.
    drive(1'b0, 1'b1, 32'h0, 32'h00001234, 5'd5, 5'd5, 5'd5);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
    #1;
    chk("pre_rst_reg5", rs_data, 32'h00001234);
    rst = 1'b1;
    #1;
    chk("async_rst_reg5", rs_data, 32'h0);
    chk("async_rst_count", commit_count, 32'h0);
    drive(1'b0, 1'b1, 32'h0, 32'h00000077, 5'd5, 5'd5, 5'd5);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd8);
    #1;
    chk("held_rst_reg5", rs_data, 32'h0);
    chk("held_rst_reg8", rt_data, 32'h0);
    chk("held_rst_count", commit_count, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'h0, 32'h00000066, 5'd6, 5'd6, 5'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd6, 5'd0);
    #1;
    chk("post_rst_reg6", rs_data, 32'h00000066);
    chk("post_rst_count", commit_count, 32'd1);

    // Counter wrap: preload the counter just below the modulus.
    force dut.count_q = 32'hFFFFFFFF;
    #1;
    release dut.count_q;
    #1;
    chk("preload_count", commit_count, 32'hFFFFFFFF);
    drive(1'b0, 1'b1, 32'h0, 32'h00000004, 5'd4, 5'd4, 5'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0);
    #1;
    chk("wrap_count", commit_count, 32'h0);
    chk("wrap_reg4", rs_data, 32'h00000004);

    // Random traffic against the array model.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    mdl_cnt = 32'h0;
    @(posedge clk); #1;
    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom,
            ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), ($urandom_range(0, 1) == 0) ? dest_reg : 5'($urandom_range(0, 31)));
      if (($urandom_range(0, 3) == 0)) rt_addr = dest_reg;
      e_wb    = mem_to_reg ? read_data : alu_result;
      e_valid = reg_write && (dest_reg != 5'd0);
      @(negedge clk);
      chk("rnd_wb_data", wb_data, e_wb);
      chk("rnd_wb_valid", {31'h0, wb_valid}, {31'h0, e_valid});
      chk("rnd_rs", rs_data, model_read(rs_addr, e_valid, dest_reg, e_wb));
      chk("rnd_rt", rt_data, model_read(rt_addr, e_valid, dest_reg, e_wb));
      chk("rnd_count", commit_count, mdl_cnt);
      @(posedge clk);
      if (e_valid) begin
        mdl[dest_reg] = e_wb;
        mdl_cnt = mdl_cnt + 32'd1;
      end
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: the write-back stage plus the architectural register file.
- Takes the registered MemToReg, RegWrite, read data, ALU result and destination register from MEM/WB.
- Selects the write-back value and commits it to a 32-entry register file.
- Serves the two ID-stage read ports, with same-cycle write-through bypass.
- Exposes the write-back value and a commit counter for forwarding and debug.

Parameters:
- DATA_W, 32, width of each register and of all data buses.
- ADDR_W, 5, register address width; the file holds 2**ADDR_W entries.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- mem_to_reg  input  1  1 selects read_data for write-back; 0 selects alu_result.
- reg_write  input  1  write-back enable from MEM/WB.
- read_data  input  DATA_W  memory load data from MEM/WB.
- alu_result  input  DATA_W  ALU result from MEM/WB.
- dest_reg  input  ADDR_W  destination register from MEM/WB.
- rs_addr  input  ADDR_W  read port A address (ID stage).
- rt_addr  input  ADDR_W  read port B address (ID stage).
- rs_data  output  DATA_W  read port A data.
- rt_data  output  DATA_W  read port B data.
- wb_data  output  DATA_W  selected write-back value, used by the forwarding unit.
- wb_valid  output  1  high when a committing write is present this cycle.
- commit_count  output  32  number of committed register writes since reset.

Behaviour:
- Reset (asynchronous, active-high):
  - rst=1 clears all 2**ADDR_W registers and commit_count to 0 immediately, with no clock edge needed.
  - While rst=1, no write and no count increment occurs on any edge.
  - Writes resume on the first rising edge after rst deasserts.
- Write-back select (combinational):
  - wb_data = mem_to_reg ? read_data : alu_result.
  - wb_valid = reg_write & (dest_reg != 0).
- Commit:
  - On a rising edge with rst=0 and wb_valid=1: reg[dest_reg] <= wb_data and commit_count <= commit_count + 1.
  - Latency: one edge.
- Register 0:
  - Hardwired to zero; never written.
  - A write to 0 with reg_write=1 is dropped and does not increment commit_count.
  - Reads of address 0 always return 0.
- Reads (combinational, zero latency):
  - rs_data = (rs_addr==0) ? 0 : (wb_valid & dest_reg==rs_addr) ? wb_data : reg[rs_addr].
  - rt_data is identical, using rt_addr.
  - The bypass removes the write-before-read hazard inside a single cycle.
- Both ports reading the same address return identical data, including in the bypass case.
- commit_count is modulo 2**32: it wraps from 0xFFFFFFFF to 0 with no flag.
- Inputs are sampled only at rising edges; X on read_data or alu_result is harmless while reg_write=0.
- No state machine is required. The state is 2**ADDR_W-1 data registers plus commit_count.

Test Plan:
- Reset: assert rst mid-run after writing reg 5 = 0x1234 -> rs_addr=5 reads 0 immediately, before any clock edge; commit_count=0.
- ALU write: mem_to_reg=0, reg_write=1, dest_reg=8, alu_result=0xDEADBEEF, one edge -> rs_addr=8 returns 0xDEADBEEF; commit_count=1.
- Load write: mem_to_reg=1, read_data=0x0000_00FF, alu_result=0x1111_1111, dest_reg=9 -> reg 9 = 0x0000_00FF.
- Bypass: with reg 10 = 0x1, present a write of 0xABCD to dest 10, and rs_addr=rt_addr=10 in the same cycle -> both ports show 0xABCD before the edge.
- Register 0: reg_write=1, dest_reg=0, alu_result=0xFFFFFFFF -> wb_valid=0; rs_addr=0 reads 0 before and after the edge; commit_count is unchanged.
- Gated write and wrap:
  - reg_write=0 with dest_reg=3 -> reg 3 is unchanged.
  - Force 2**32 commits (or preload the counter in simulation) -> commit_count wraps to 0.
